// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks an inclusive register-file address range and streams
// each register's contents out over a valid/ready handshake, one word per
// FETCH/SEND pair. All outputs are driven straight from flops.
module reg_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [ADDR_W-1:0]   last_r, last_nxt_s;
  logic [ADDR_W-1:0]   rd_addr_r, rd_addr_nxt_s;
  logic [DATA_W-1:0]   out_data_r, out_data_nxt_s;
  logic [ADDR_W-1:0]   out_addr_r, out_addr_nxt_s;
  logic                out_last_r, out_last_nxt_s;
  logic                out_valid_r, out_valid_nxt_s;
  logic                busy_r, busy_nxt_s;
  logic                done_r, done_nxt_s;
  logic                err_r, err_nxt_s;

  // Next-state and next-output decode; every register defaults to holding.
  always_comb begin
    state_nxt_s     = state_r;
    last_nxt_s      = last_r;
    rd_addr_nxt_s   = rd_addr_r;
    out_data_nxt_s  = out_data_r;
    out_addr_nxt_s  = out_addr_r;
    out_last_nxt_s  = out_last_r;
    out_valid_nxt_s = out_valid_r;
    done_nxt_s      = 1'b0;
    err_nxt_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (first_addr <= last_addr) begin
            last_nxt_s    = last_addr;
            rd_addr_nxt_s = first_addr;
            state_nxt_s   = FETCH;
          end else begin
            err_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH: begin
        out_data_nxt_s  = rd_data;
        out_addr_nxt_s  = rd_addr_r;
        out_last_nxt_s  = (rd_addr_r == last_r);
        out_valid_nxt_s = 1'b1;
        state_nxt_s     = SEND;
      end
      SEND: begin
        if (out_ready) begin
          out_valid_nxt_s = 1'b0;
          if (out_last_r) begin
            // Range finished; no increment, so last_addr = max never wraps.
            done_nxt_s  = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            rd_addr_nxt_s = rd_addr_r + ADDR_W'(1);
            state_nxt_s   = FETCH;
          end
        end else begin
          state_nxt_s = SEND;
        end
      end
      default: begin
        out_valid_nxt_s = 1'b0;
        state_nxt_s     = IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s != IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      last_r      <= '0;
      rd_addr_r   <= '0;
      out_data_r  <= '0;
      out_addr_r  <= '0;
      out_last_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      last_r      <= last_nxt_s;
      rd_addr_r   <= rd_addr_nxt_s;
      out_data_r  <= out_data_nxt_s;
      out_addr_r  <= out_addr_nxt_s;
      out_last_r  <= out_last_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      err_r       <= err_nxt_s;
    end
  end

  assign rd_addr   = rd_addr_r;
  assign out_data  = out_data_r;
  assign out_addr  = out_addr_r;
  assign out_last  = out_last_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: a behavioural register file answers
// rd_addr combinationally; inputs change and outputs are sampled on negedge.
module tb_reg_dump_reader;

  logic        clk, rst, start, out_ready;
  logic [4:0]  first_addr, last_addr, rd_addr, out_addr;
  logic [31:0] rd_data, out_data;
  logic        out_valid, out_last, busy, done, err;
  logic [31:0] regfile [0:31];
  int          errors = 0;
  int          checks = 0;

  assign rd_data = regfile[rd_addr];

  reg_dump_reader #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .first_addr(first_addr),
    .last_addr(last_addr), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done),
    .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // done and err must never coincide
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (done && err) begin
        errors++;
        $display("FAIL done_err_overlap: done=%0b err=%0b required not both 1", done, err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Pulse start for one edge; returns at the negedge just after acceptance.
  task automatic do_start(input logic [4:0] f, input logic [4:0] l);
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({rd_addr, out_data, out_addr} !== 42'd0) begin
      errors++;
      $display("FAIL reset_data: got %0h required 0", {rd_addr, out_data, out_addr});
    end
    checks++;
    if ({out_valid, out_last, busy, done, err} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 00000", {out_valid, out_last, busy, done, err});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, busy, done, err} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b required 0000", {out_valid, busy, done, err});
    end
  endtask

  task automatic test_basic;
    logic [4:0]  ea;
    logic [31:0] ed;
    out_ready = 1'b1;
    do_start(5'd1, 5'd3);
    for (int c = 0; c < 8; c++) begin
      ea = 5'((c + 1) / 2);
      ed = 32'h11 * 32'((c + 1) / 2);
      checks++;
      if (out_valid !== ((c % 2 == 1) && (c <= 5))) begin
        errors++;
        $display("FAIL basic_valid c=%0d: got %b required %b", c, out_valid, ((c % 2 == 1) && (c <= 5)));
      end
      if ((c % 2 == 1) && (c <= 5)) begin
        checks++;
        if (out_addr !== ea || out_data !== ed || out_last !== (c == 5)) begin
          errors++;
          $display("FAIL basic_word c=%0d: got (%0d,%0h,%b) required (%0d,%0h,%b)", c, out_addr, out_data, out_last, ea, ed, (c == 5));
        end
      end
      checks++;
      if (done !== (c == 6) || busy !== (c < 6)) begin
        errors++;
        $display("FAIL basic_done_busy c=%0d: got done=%b busy=%b required done=%b busy=%b", c, done, busy, (c == 6), (c < 6));
      end
      @(negedge clk);
    end
    checks++;
    if (rd_addr !== 5'd3) begin
      errors++;
      $display("FAIL idle_rd_addr_hold: got %0d required 3", rd_addr);
    end
  endtask

  task automatic test_backpressure;
    int words = 0;
    int hold = 0;
    bit seen_done = 1'b0;
    out_ready = 1'b1;
    do_start(5'd1, 5'd3);
    for (int c = 0; c < 40 && !seen_done; c++) begin
      if (out_valid) begin
        checks++;
        if (out_addr !== 5'(words + 1) || out_data !== 32'h11 * 32'(words + 1) || out_last !== (words == 2)) begin
          errors++;
          $display("FAIL bp_word w=%0d hold=%0d: got (%0d,%0h,%b) required (%0d,%0h,%b)", words, hold, out_addr, out_data, out_last, words + 1, 32'h11 * 32'(words + 1), (words == 2));
        end
        if (words == 1 && hold < 4) begin
          out_ready = 1'b0;
          hold++;
        end else begin
          out_ready = 1'b1;
          words++;
        end
      end
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (!seen_done || words != 3 || hold != 4) begin
      errors++;
      $display("FAIL bp_summary: got done=%0b words=%0d hold=%0d required 1,3,4", seen_done, words, hold);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL bp_done_pulse: got %b required 0", done);
    end
  endtask

  task automatic test_err;
    out_ready = 1'b1;
    do_start(5'd5, 5'd2);
    checks++;
    if ({err, busy, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL err_pulse: got err/busy/valid=%b required 100", {err, busy, out_valid});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({err, busy, out_valid} !== 3'b000) begin
        errors++;
        $display("FAIL err_after c=%0d: got err/busy/valid=%b required 000", c, {err, busy, out_valid});
      end
    end
  endtask

  task automatic test_single_31;
    out_ready = 1'b1;
    do_start(5'd31, 5'd31);
    checks++;
    if ({busy, out_valid} !== 2'b10 || rd_addr !== 5'd31) begin
      errors++;
      $display("FAIL s31_c0: got busy/valid=%b rd_addr=%0d required 10,31", {busy, out_valid}, rd_addr);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 5'd31 || out_data !== 32'hDEADBEEF || out_last !== 1'b1) begin
      errors++;
      $display("FAIL s31_word: got (%b,%0d,%0h,%b) required (1,31,deadbeef,1)", out_valid, out_addr, out_data, out_last);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || rd_addr !== 5'd31) begin
      errors++;
      $display("FAIL s31_done: got done=%b valid=%b rd_addr=%0d required 1,0,31", done, out_valid, rd_addr);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || rd_addr !== 5'd31) begin
      errors++;
      $display("FAIL s31_idle: got done=%b busy=%b valid=%b rd_addr=%0d required 0,0,0,31", done, busy, out_valid, rd_addr);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    do_start(5'd1, 5'd4);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 5'd2 || out_data !== 32'h22) begin
      errors++;
      $display("FAIL rm_word2: got (%b,%0d,%0h) required (1,2,22)", out_valid, out_addr, out_data);
    end
    out_ready = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({rd_addr, out_data, out_addr} !== 42'd0 || {out_valid, out_last, busy, done, err} !== 5'b00000) begin
      errors++;
      $display("FAIL rm_async: got data=%0h flags=%b required 0,00000", {rd_addr, out_data, out_addr}, {out_valid, out_last, busy, done, err});
    end
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({done, busy, out_valid} !== 3'b000) begin
        errors++;
        $display("FAIL rm_no_done c=%0d: got done/busy/valid=%b required 000", c, {done, busy, out_valid});
      end
    end
    do_start(5'd1, 5'd1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 5'd1 || out_data !== 32'h11 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL rm_fresh_word: got (%b,%0d,%0h,%b) required (1,1,11,1)", out_valid, out_addr, out_data, out_last);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_fresh_done: got done=%b valid=%b required 1,0", done, out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    logic [4:0]  ea;
    logic [31:0] ed;
    out_ready = 1'b1;
    do_start(5'd1, 5'd3);
    for (int c = 0; c < 8; c++) begin
      ea = 5'((c + 1) / 2);
      ed = 32'h11 * 32'((c + 1) / 2);
      checks++;
      if (out_valid !== ((c % 2 == 1) && (c <= 5))) begin
        errors++;
        $display("FAIL ign_valid c=%0d: got %b required %b", c, out_valid, ((c % 2 == 1) && (c <= 5)));
      end
      if ((c % 2 == 1) && (c <= 5)) begin
        checks++;
        if (out_addr !== ea || out_data !== ed || out_last !== (c == 5)) begin
          errors++;
          $display("FAIL ign_word c=%0d: got (%0d,%0h,%b) required (%0d,%0h,%b)", c, out_addr, out_data, out_last, ea, ed, (c == 5));
        end
      end
      checks++;
      if (done !== (c == 6)) begin
        errors++;
        $display("FAIL ign_done c=%0d: got %b required %b", c, done, (c == 6));
      end
      if (c == 2 || c == 3) begin
        first_addr = 5'd7;
        last_addr  = 5'd9;
        start      = 1'b1;
      end else begin
        start      = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regfile[i] = 32'hA5000000 | 32'(i);
    regfile[0]  = 32'h00000000;
    regfile[1]  = 32'h00000011;
    regfile[2]  = 32'h00000022;
    regfile[3]  = 32'h00000033;
    regfile[4]  = 32'h00000044;
    regfile[31] = 32'hDEADBEEF;
    rst        = 1'b0;
    start      = 1'b0;
    out_ready  = 1'b0;
    first_addr = 5'd0;
    last_addr  = 5'd0;
    test_reset();
    test_basic();
    test_backpressure();
    test_err();
    test_single_31();
    test_reset_mid();
    test_ignore_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
